irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 The module SHALL have parameter BASE, default 8'h10, the port_id base address; registers occupy BASE+0..BASE+3.
REQ-002 The module SHALL have parameter SYNC_STAGES, default 2, the number of synchroniser flops per source input (legal range 2..3).
REQ-003 clk  input  1  single system clock (32 MHz); all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 src  input  8  asynchronous interrupt sources (board switches/buttons); rising-edge triggered.
REQ-006 port_id  input  8  processor I/O address.
REQ-007 write_strobe  input  1  processor write qualifier, one cycle.
REQ-008 read_strobe  input  1  processor read qualifier, one cycle; informational only, no side effects.
REQ-009 out_port  input  8  processor write data.
REQ-010 in_port  output  8  registered read data to processor.
REQ-011 interrupt  output  1  registered interrupt request to processor irq.
REQ-012 interrupt_ack  input  1  one-cycle acknowledge from processor.

Function
REQ-013 Each src bit SHALL pass through SYNC_STAGES flops, then a one-flop rising-edge detector; edge latency from src change to PEND set SHALL be SYNC_STAGES+1 cycles.
REQ-014 Register map: BASE+0 PEND (R, write-1-to-clear); BASE+1 MASK (R/W, 1 = enabled); BASE+2 VEC (R only); BASE+3 EOI (W only, data ignored; reads return 8'h00).
REQ-015 PEND[i] SHALL set on detected edge of src[i] regardless of MASK.
REQ-016 Edge on bit i in the same cycle as a W1C of bit i SHALL leave PEND[i]=1 (set wins).
REQ-017 ACT = PEND & MASK; priority SHALL be fixed, bit 0 highest.
REQ-018 VEC SHALL read {valid,4'b0,idx[2:0]}: the latched service index with valid=1 while in SERVICE, otherwise the current highest ACT index with valid=|ACT.
REQ-019 in_port SHALL be a registered mux of port_id updated every cycle (valid one cycle after port_id); unmapped addresses SHALL return 8'h00.
REQ-020 Writes SHALL take effect only when write_strobe=1 and port_id matches; all writes are side-effect-free for other addresses.
REQ-021 FSM states IDLE, REQ, SERVICE.
REQ-022 IDLE -> REQ when |ACT=1; interrupt SHALL rise the following cycle.
REQ-023 REQ: interrupt held 1; on interrupt_ack latch idx of highest ACT, clear that PEND bit, go SERVICE, interrupt drops next cycle.
REQ-024 REQ with ACT becoming 0 (mask or W1C) before ack SHALL return to IDLE and drop interrupt; ack in IDLE or SERVICE SHALL be ignored.
REQ-025 SERVICE: interrupt held 0; new edges accumulate in PEND; EOI write -> IDLE; if ACT nonzero, re-enter REQ the next cycle (no nesting).
REQ-026 MASK write in SERVICE SHALL not disturb the latched index.

Reset
REQ-027 On rst=0, asynchronously: PEND=0, MASK=0, synchroniser and edge flops=0, FSM=IDLE, interrupt=0, in_port=8'h00, latched idx=0.
REQ-028 A src held high through reset release SHALL NOT produce an edge (detector flops reset to 0 but first edge is only asserted after synchroniser has carried a 0->1 transition).
REQ-029 Reset mid-SERVICE or mid-REQ SHALL abandon the transaction with no residual interrupt.

Verification
REQ-030 MASK=8'h04, pulse src[2] -> PEND=8'h04 after 3 cycles, interrupt=1 next cycle; ack -> VEC read 8'h82, PEND=0, interrupt=0.
REQ-031 MASK=8'hFF, src[5] and src[1] rise together -> ack services idx 1 (VEC 8'h81); EOI -> interrupt reasserts, second ack gives VEC 8'h85.
REQ-032 MASK=0, pulse src[3] -> PEND=8'h08, interrupt stays 0; write MASK=8'h08 -> interrupt=1 within 2 cycles.
REQ-033 In REQ, write PEND=8'hFF (W1C all) before ack -> FSM IDLE, interrupt=0; same-cycle src[0] edge with W1C of bit 0 -> PEND[0]=1.
REQ-034 src[7] held high across reset release -> PEND stays 0; assert rst=0 during SERVICE -> all outputs 0 asynchronously, read of BASE+1 after release = 8'h00.

Source files
------------

// File: rtl/irq_ctrl.sv
// Purpose : 8-source edge-triggered interrupt controller on a processor port_id/strobe bus.
// Latency : src edge -> PEND in SYNC_STAGES+1 cycles; PEND -> interrupt +1 cycle; in_port one cycle after port_id.
// Backpr. : none; the request is held until the processor acks, and new edges wait in PEND until EOI.
module irq_ctrl #(
    parameter logic [7:0] BASE        = 8'h10,
    parameter int         SYNC_STAGES = 2      // legal range 2..3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] src,
    input  logic [7:0] port_id,
    input  logic       write_strobe,
    input  logic       read_strobe,
    input  logic [7:0] out_port,
    output logic [7:0] in_port,
    output logic       interrupt,
    input  logic       interrupt_ack
);

    localparam logic [7:0] A_PEND = BASE;
    localparam logic [7:0] A_MASK = BASE + 8'd1;
    localparam logic [7:0] A_VEC  = BASE + 8'd2;
    localparam logic [7:0] A_EOI  = BASE + 8'd3;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_SERVICE = 2'd2;

    // Reads have no side effects, so the read qualifier is deliberately unused.
    logic w_unused_rd;
    assign w_unused_rd = read_strobe;

    logic [7:0]         r_sync [SYNC_STAGES];
    logic [SYNC_STAGES:0] r_fill;
    logic [7:0]         r_prev;
    logic [7:0]         r_pend;
    logic [7:0]         r_mask;
    logic [2:0]         r_idx;
    logic [1:0]         r_state;
    logic               r_irq;
    logic [7:0]         r_in_port;

    logic [7:0] w_sync_last;
    logic       w_armed;
    logic [7:0] w_edge;
    logic [7:0] w_act;
    logic       w_any;
    logic [2:0] w_idx;
    logic       w_take;
    logic [7:0] w_svc_clr;
    logic [7:0] w_w1c;
    logic       w_wr_mask;
    logic       w_wr_eoi;
    logic [7:0] w_vec;
    logic [7:0] w_rd_dat;
    logic [1:0] w_state_nxt;

    // Synchroniser chain for the asynchronous sources.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 8'h00;
        end else begin
            r_sync[0] <= src;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    // Arming shift register: edges count only once both the synchroniser output
    // and the previous-value flop hold genuine post-reset samples, so a source
    // already high at reset release never looks like a 0->1 transition.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_fill <= '0;
        else      r_fill <= {r_fill[SYNC_STAGES-1:0], 1'b1};
    end

    // Previous synchronised value for the rising-edge detector.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_prev <= 8'h00;
        else      r_prev <= w_sync_last;
    end

    assign w_sync_last = r_sync[SYNC_STAGES-1];
    assign w_armed     = r_fill[SYNC_STAGES];
    assign w_edge      = w_armed ? (w_sync_last & ~r_prev) : 8'h00;

    assign w_act = r_pend & r_mask;
    assign w_any = |w_act;

    // Fixed priority: lowest set bit of ACT wins.
    always_comb begin
        w_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_act[i]) w_idx = 3'(i);
        end
    end

    assign w_take    = (r_state == S_REQ) && interrupt_ack && w_any;
    assign w_svc_clr = w_take ? (8'h01 << w_idx) : 8'h00;
    assign w_w1c     = (write_strobe && (port_id == A_PEND)) ? out_port : 8'h00;
    assign w_wr_mask = write_strobe && (port_id == A_MASK);
    assign w_wr_eoi  = write_strobe && (port_id == A_EOI);

    // Pending bits: an edge in the same cycle as a clear keeps the bit set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_pend <= 8'h00;
        else      r_pend <= (r_pend & ~w_w1c & ~w_svc_clr) | w_edge;
    end

    // Mask register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           r_mask <= 8'h00;
        else if (w_wr_mask) r_mask <= out_port;
    end

    // Service index is captured only on the accepted ack, so mask writes during
    // service cannot alter it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        r_idx <= 3'd0;
        else if (w_take) r_idx <= w_idx;
    end

    // Next-state logic; acks outside REQ fall through untouched.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_any) w_state_nxt = S_REQ;
            S_REQ: begin
                if (!w_any)      w_state_nxt = S_IDLE;
                else if (w_take) w_state_nxt = S_SERVICE;
            end
            S_SERVICE: if (w_wr_eoi) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // State register and registered interrupt line (high exactly while in REQ).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_irq   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_irq   <= (w_state_nxt == S_REQ);
        end
    end

    assign w_vec = (r_state == S_SERVICE) ? {1'b1, 4'b0000, r_idx}
                                          : {w_any, 4'b0000, w_idx};

    // Read mux; EOI and unmapped addresses read as zero.
    always_comb begin
        w_rd_dat = 8'h00;
        if (port_id == A_PEND)      w_rd_dat = r_pend;
        else if (port_id == A_MASK) w_rd_dat = r_mask;
        else if (port_id == A_VEC)  w_rd_dat = w_vec;
    end

    // Registered read data, refreshed every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_in_port <= 8'h00;
        else      r_in_port <= w_rd_dat;
    end

    assign in_port   = r_in_port;
    assign interrupt = r_irq;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed table-driven bench for irq_ctrl: one record per clock cycle, plus
// hand-written reset sequences for the asynchronous corner cases.
module tb_irq_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] src;
    logic [7:0] port_id;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] out_port;
    logic [7:0] in_port;
    logic       interrupt;
    logic       interrupt_ack;

    int n_tests = 0;
    int n_fail  = 0;

    irq_ctrl #(.BASE(8'h10), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .src          (src),
        .port_id      (port_id),
        .write_strobe (write_strobe),
        .read_strobe  (read_strobe),
        .out_port     (out_port),
        .in_port      (in_port),
        .interrupt    (interrupt),
        .interrupt_ack(interrupt_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] src;
        logic [7:0] port;
        logic       wr;
        logic [7:0] wdata;
        logic       ack;
        logic       chk_in;
        logic [7:0] exp_in;
        logic       exp_irq;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic [7:0] s, input logic [7:0] p, input logic w,
                               input logic [7:0] d, input logic a, input logic c,
                               input logic [7:0] ei, input logic eq);
        vec_t r;
        r.src = s; r.port = p; r.wr = w; r.wdata = d; r.ack = a;
        r.chk_in = c; r.exp_in = ei; r.exp_irq = eq;
        return r;
    endfunction

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Apply one record for one clock edge, then check outputs 1 time unit later.
    task automatic step(input vec_t t, input string tag);
        src           = t.src;
        port_id       = t.port;
        write_strobe  = t.wr;
        out_port      = t.wdata;
        interrupt_ack = t.ack;
        read_strobe   = ~t.wr;
        @(posedge clk);
        #1;
        chk8({tag, ".irq"}, {7'd0, interrupt}, {7'd0, t.exp_irq});
        if (t.chk_in) chk8({tag, ".in_port"}, in_port, t.exp_in);
    endtask

    initial begin
        src = 8'h00; port_id = 8'h00; write_strobe = 1'b0; read_strobe = 1'b0;
        out_port = 8'h00; interrupt_ack = 1'b0;

        // Reset state, asserted asynchronously between edges.
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        chk8("reset.irq", {7'd0, interrupt}, 8'h00);
        chk8("reset.in_port", in_port, 8'h00);
        #10 rst = 1'b1;

        // Idle cycles: lets the edge detector arm; unmapped address reads zero.
        for (int i = 0; i < 5; i++) tbl.push_back(v(8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h00, 0));

        // Single source, masked in: SYNC_STAGES+1 latency, ack, EOI.
        tbl.push_back(v(8'h00, 8'h11, 1, 8'h04, 0, 0, 8'h00, 0));
        tbl.push_back(v(8'h04, 8'h11, 0, 8'h00, 0, 1, 8'h04, 0));
        tbl.push_back(v(8'h00, 8'h10, 0, 8'h00, 0, 1, 8'h00, 0));
        tbl.push_back(v(8'h00, 8'h10, 0, 8'h00, 0, 1, 8'h00, 0));
        tbl.push_back(v(8'h00, 8'h10, 0, 8'h00, 0, 1, 8'h04, 1));
        tbl.push_back(v(8'h00, 8'h12, 0, 8'h00, 0, 1, 8'h82, 1));
        tbl.push_back(v(8'h00, 8'h12, 0, 8'h00, 1, 1, 8'h82, 0));
        tbl.push_back(v(8'h00, 8'h12, 0, 8'h00, 0, 1, 8'h82, 0));
        tbl.push_back(v(8'h00, 8'h10, 0, 8'h00, 0, 1, 8'h00, 0));
        tbl.push_back(v(8'h00, 8'h13, 1, 8'h00, 0, 1, 8'h00, 0));
        tbl.push_back(v(8'h00, 8'h12, 0, 8'h00, 0, 1, 8'h00, 0));

        // Two simultaneous sources: priority, mask write and ack during service, re-request after EOI.
        tbl.push_back(v(8'h00, 8'h11, 1, 8'hFF, 0, 0, 8'h00, 0));
        tbl.push_back(v(8'h22, 8'h11, 0, 8'h00, 0, 1, 8'hFF, 0));
        tbl.push_back(v(8'h00, 8'h10, 0, 8'h00, 0, 1, 8'h00, 0));
        tbl.push_back(v(8'h00, 8'h10, 0, 8'h00, 0, 1, 8'h00, 0));
        tbl.push_back(v(8'h00, 8'h10, 0, 8'h00, 0, 1, 8'h22, 1));
        tbl.push_back(v(8'h00, 8'h12, 0, 8'h00, 1, 1, 8'h81, 0));
        tbl.push_back(v(8'h00, 8'h11, 1, 8'hFD, 0, 1, 8'hFF, 0));
        tbl.push_back(v(8'h00, 8'h12, 0, 8'h00, 1, 1, 8'h81, 0));
        tbl.push_back(v(8'h00, 8'h10, 0, 8'h00, 0, 1, 8'h20, 0));
        tbl.push_back(v(8'h00, 8'h13, 1, 8'h00, 0, 1, 8'h00, 0));
        tbl.push_back(v(8'h00, 8'h12, 0, 8'h00, 0, 1, 8'h85, 1));
        tbl.push_back(v(8'h00, 8'h12, 0, 8'h00, 1, 1, 8'h85, 0));
        tbl.push_back(v(8'h00, 8'h12, 0, 8'h00, 0, 1, 8'h85, 0));
        tbl.push_back(v(8'h00, 8'h13, 1, 8'h00, 0, 1, 8'h00, 0));
        tbl.push_back(v(8'h00, 8'h10, 0, 8'h00, 0, 1, 8'h00, 0));

        // Masked source pends silently, then unmasking raises the request.
        tbl.push_back(v(8'h00, 8'h11, 1, 8'h00, 0, 0, 8'h00, 0));
        tbl.push_back(v(8'h08, 8'h11, 0, 8'h00, 0, 1, 8'h00, 0));
        tbl.push_back(v(8'h00, 8'h10, 0, 8'h00, 0, 1, 8'h00, 0));
        tbl.push_back(v(8'h00, 8'h10, 0, 8'h00, 0, 1, 8'h00, 0));
        tbl.push_back(v(8'h00, 8'h10, 0, 8'h00, 0, 1, 8'h08, 0));
        tbl.push_back(v(8'h00, 8'h12, 0, 8'h00, 1, 1, 8'h00, 0));
        tbl.push_back(v(8'h00, 8'h11, 1, 8'h08, 0, 1, 8'h00, 0));
        tbl.push_back(v(8'h00, 8'h12, 0, 8'h00, 0, 1, 8'h83, 1));

        // W1C of all pending bits in REQ withdraws the request.
        tbl.push_back(v(8'h00, 8'h10, 1, 8'hFF, 0, 1, 8'h08, 1));
        tbl.push_back(v(8'h00, 8'h10, 0, 8'h00, 0, 1, 8'h00, 0));
        tbl.push_back(v(8'h00, 8'h12, 0, 8'h00, 0, 1, 8'h00, 0));

        // Edge on bit 0 lands in the same cycle as a W1C of bit 0: set wins.
        tbl.push_back(v(8'h01, 8'h12, 0, 8'h00, 0, 1, 8'h00, 0));
        tbl.push_back(v(8'h00, 8'h12, 0, 8'h00, 0, 1, 8'h00, 0));
        tbl.push_back(v(8'h00, 8'h10, 1, 8'h01, 0, 1, 8'h00, 0));
        tbl.push_back(v(8'h00, 8'h10, 0, 8'h00, 0, 1, 8'h01, 0));
        tbl.push_back(v(8'h00, 8'h10, 1, 8'h01, 0, 1, 8'h01, 0));
        tbl.push_back(v(8'h00, 8'h10, 0, 8'h00, 0, 1, 8'h00, 0));

        // Unmapped reads, unmapped writes, and data without write_strobe.
        tbl.push_back(v(8'h00, 8'h20, 0, 8'h00, 0, 1, 8'h00, 0));
        tbl.push_back(v(8'h00, 8'h14, 1, 8'hFF, 0, 1, 8'h00, 0));
        tbl.push_back(v(8'h00, 8'h11, 0, 8'hFF, 0, 1, 8'h08, 0));
        tbl.push_back(v(8'h00, 8'h11, 0, 8'h00, 0, 1, 8'h08, 0));

        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // Reset in REQ with src[7] (and src[6]) held high across release.
        step(v(8'h00, 8'h11, 1, 8'hFF, 0, 0, 8'h00, 0), "req.mask");
        step(v(8'h40, 8'h10, 0, 8'h00, 0, 0, 8'h00, 0), "req.e1");
        step(v(8'h40, 8'h10, 0, 8'h00, 0, 0, 8'h00, 0), "req.e2");
        step(v(8'h40, 8'h10, 0, 8'h00, 0, 1, 8'h00, 0), "req.e3");
        step(v(8'h40, 8'h10, 0, 8'h00, 0, 1, 8'h40, 1), "req.irq");
        #2 rst = 1'b0; src = 8'hC0;
        #1;
        chk8("req_rst.irq", {7'd0, interrupt}, 8'h00);
        chk8("req_rst.in_port", in_port, 8'h00);
        #3 rst = 1'b1;
        for (int i = 0; i < 6; i++) step(v(8'hC0, 8'h10, 0, 8'h00, 0, 1, 8'h00, 0), $sformatf("held%0d", i));
        step(v(8'hC0, 8'h11, 0, 8'h00, 0, 1, 8'h00, 0), "req_rst.mask");

        // Reset in SERVICE while reading VEC.
        step(v(8'h80, 8'h11, 1, 8'hFF, 0, 1, 8'h00, 0), "svc.mask");
        step(v(8'h80, 8'h10, 0, 8'h00, 0, 1, 8'h00, 0), "svc.low1");
        step(v(8'h80, 8'h10, 0, 8'h00, 0, 1, 8'h00, 0), "svc.low2");
        step(v(8'hC0, 8'h10, 0, 8'h00, 0, 1, 8'h00, 0), "svc.e1");
        step(v(8'hC0, 8'h10, 0, 8'h00, 0, 1, 8'h00, 0), "svc.e2");
        step(v(8'hC0, 8'h10, 0, 8'h00, 0, 1, 8'h00, 0), "svc.e3");
        step(v(8'hC0, 8'h12, 0, 8'h00, 0, 1, 8'h86, 1), "svc.irq");
        step(v(8'hC0, 8'h12, 0, 8'h00, 1, 1, 8'h86, 0), "svc.ack");
        step(v(8'hC0, 8'h12, 0, 8'h00, 0, 1, 8'h86, 0), "svc.vec");
        #2 rst = 1'b0;
        #1;
        chk8("svc_rst.irq", {7'd0, interrupt}, 8'h00);
        chk8("svc_rst.in_port", in_port, 8'h00);
        #3 rst = 1'b1;
        for (int i = 0; i < 4; i++) step(v(8'hC0, 8'h11, 0, 8'h00, 0, 1, 8'h00, 0), $sformatf("post%0d", i));
        step(v(8'hC0, 8'h10, 0, 8'h00, 0, 1, 8'h00, 0), "post.pend");
        step(v(8'hC0, 8'h12, 0, 8'h00, 0, 1, 8'h00, 0), "post.vec");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
